// File: rtl/fp_cmp_issue.sv
// Operand issue stage for the single-precision FLE/FLT/FEQ comparator: forwards
// writebacks, decodes funct3, classifies NaNs, and buffers ops in an output register plus skid entry.
module fp_cmp_issue #(
  parameter logic [7:0] NAN_EXP = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rs1_addr,
  input  logic [4:0]  in_rs2_addr,
  input  logic [4:0]  in_rd_addr,
  input  logic [31:0] in_read_data1,
  input  logic [31:0] in_read_data2,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_read_data1,
  output logic [31:0] out_read_data2,
  output logic [2:0]  out_op,
  output logic [4:0]  out_rd_addr,
  output logic        out_nan,
  output logic        out_snan,
  output logic        illegal_op
);

  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  op;
    logic [4:0]  rd;
  } entry_t;

  entry_t or_q, sk_q;
  entry_t or_snoop, sk_snoop, new_entry;
  logic   or_valid, sk_valid;
  logic   illegal_q;
  logic   accept, consume, legal, load;
  logic [2:0] dec_op;

  // Stored operands track any later writeback to their source register.
  function automatic entry_t snoop(input entry_t e, input logic en,
                                   input logic [4:0] addr, input logic [31:0] data);
    entry_t r;
    r = e;
    if (en && addr == e.rs1) r.data1 = data;
    if (en && addr == e.rs2) r.data2 = data;
    return r;
  endfunction

  function automatic logic is_nan(input logic [31:0] d);
    return (d[30:23] == NAN_EXP) && (d[22:0] != 23'd0);
  endfunction

  function automatic logic is_snan(input logic [31:0] d);
    return is_nan(d) && !d[22];
  endfunction

  always_comb begin
    dec_op = 3'b000;
    legal  = 1'b0;
    case (in_funct3)
      3'b000:  begin dec_op = 3'b001; legal = 1'b1; end
      3'b001:  begin dec_op = 3'b010; legal = 1'b1; end
      3'b010:  begin dec_op = 3'b100; legal = 1'b1; end
      default: begin dec_op = 3'b000; legal = 1'b0; end
    endcase
  end

  assign in_ready = !sk_valid && !flush && !rst;
  assign accept   = in_valid && in_ready;
  assign load     = accept && legal;
  assign consume  = or_valid && out_ready;

  always_comb begin
    new_entry.data1 = (wb_en && wb_addr == in_rs1_addr) ? wb_data : in_read_data1;
    new_entry.data2 = (wb_en && wb_addr == in_rs2_addr) ? wb_data : in_read_data2;
    new_entry.rs1   = in_rs1_addr;
    new_entry.rs2   = in_rs2_addr;
    new_entry.op    = dec_op;
    new_entry.rd    = in_rd_addr;
    or_snoop        = snoop(or_q, wb_en, wb_addr, wb_data);
    sk_snoop        = snoop(sk_q, wb_en, wb_addr, wb_data);
  end

  // OR always holds the older op; SK only fills when OR is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      or_q      <= '0;
      sk_q      <= '0;
      or_valid  <= 1'b0;
      sk_valid  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !legal;
      if (flush) begin
        or_valid <= 1'b0;
        sk_valid <= 1'b0;
      end else begin
        or_q <= or_snoop;
        sk_q <= sk_snoop;
        if (consume) begin
          if (sk_valid) begin
            or_q     <= sk_snoop;
            sk_valid <= 1'b0;
          end else if (load) begin
            or_q <= new_entry;
          end else begin
            or_valid <= 1'b0;
          end
        end else if (load) begin
          if (!or_valid) begin
            or_q     <= new_entry;
            or_valid <= 1'b1;
          end else begin
            sk_q     <= new_entry;
            sk_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign out_valid      = or_valid;
  assign out_read_data1 = or_q.data1;
  assign out_read_data2 = or_q.data2;
  assign out_op         = or_q.op;
  assign out_rd_addr    = or_q.rd;
  assign out_nan        = or_valid && (is_nan(or_q.data1) || is_nan(or_q.data2));
  assign out_snan       = or_valid && (is_snan(or_q.data1) || is_snan(or_q.data2));
  assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_fp_cmp_issue.sv
// Self-checking bench for fp_cmp_issue: directed scenarios plus randomized traffic
// compared against a two-deep FIFO reference model with forwarding and snooping.
module tb_fp_cmp_issue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_read_data1, in_read_data2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_read_data1, out_read_data2;
  logic [2:0]  out_op;
  logic [4:0]  out_rd_addr;
  logic        out_nan, out_snan, illegal_op;

  int checks = 0;
  int errors = 0;

  fp_cmp_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr), .in_read_data1(in_read_data1), .in_read_data2(in_read_data2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_read_data1(out_read_data1), .out_read_data2(out_read_data2),
    .out_op(out_op), .out_rd_addr(out_rd_addr), .out_nan(out_nan), .out_snan(out_snan),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Reference model: queue of pending ops, head is what should be on the outputs.
  typedef struct {
    logic [31:0] d1, d2;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
  } op_t;
  op_t  q[$];
  logic m_illegal = 1'b0;

  function automatic logic ref_nan(input logic [31:0] d);
    return (d[30:23] == 8'hFF) && (d[22:0] != 0);
  endfunction

  function automatic logic ref_snan(input logic [31:0] d);
    return ref_nan(d) && (d[22] == 1'b0);
  endfunction

  function automatic logic [2:0] ref_op(input logic [2:0] f3);
    return 3'(1 << f3);
  endfunction

  task automatic model_edge();
    op_t n;
    bit  acc;
    if (rst || flush) begin
      q.delete();
      m_illegal = 1'b0;
    end else begin
      acc = in_valid && (q.size() < 2);
      foreach (q[i]) begin
        if (wb_en && wb_addr == q[i].rs1) q[i].d1 = wb_data;
        if (wb_en && wb_addr == q[i].rs2) q[i].d2 = wb_data;
      end
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      m_illegal = acc && (in_funct3 > 3'd2);
      if (acc && in_funct3 <= 3'd2) begin
        n.d1  = (wb_en && wb_addr == in_rs1_addr) ? wb_data : in_read_data1;
        n.d2  = (wb_en && wb_addr == in_rs2_addr) ? wb_data : in_read_data2;
        n.rs1 = in_rs1_addr;
        n.rs2 = in_rs2_addr;
        n.rd  = in_rd_addr;
        n.f3  = in_funct3;
        q.push_back(n);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_req(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
    in_valid = 1'b1; in_funct3 = f3; in_rs1_addr = rs1; in_rs2_addr = rs2;
    in_rd_addr = rd; in_read_data1 = d1; in_read_data2 = d2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_read_data1 !== 32'd0 || out_read_data2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_data got %h/%h want 0", out_read_data1, out_read_data2); end
    checks++; if (out_op !== 3'b000 || out_rd_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_op_rd got %b/%0d want 000/0", out_op, out_rd_addr); end
    checks++; if (out_nan !== 1'b0 || out_snan !== 1'b0 || illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %b%b%b want 000", out_nan, out_snan, illegal_op); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single_op();
    out_ready = 1'b1;
    set_req(3'b000, 5'd1, 5'd2, 5'd3, 32'h3F800000, 32'h40000000);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b want 1", out_valid); end
    checks++; if (out_read_data1 !== 32'h3F800000 || out_read_data2 !== 32'h40000000) begin errors++; $display("[TB] FAIL single_data got %h/%h want 3f800000/40000000", out_read_data1, out_read_data2); end
    checks++; if (out_op !== 3'b001 || out_rd_addr !== 5'd3) begin errors++; $display("[TB] FAIL single_op_rd got %b/%0d want 001/3", out_op, out_rd_addr); end
    checks++; if (out_nan !== 1'b0) begin errors++; $display("[TB] FAIL single_nan got %b want 0", out_nan); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b0;
    set_req(3'b001, 5'd6, 5'd7, 5'd4, 32'h11111111, 32'h22222222);
    tick();
    set_req(3'b010, 5'd8, 5'd9, 5'd5, 32'h33333333, 32'h44444444);
    tick();
    in_valid = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL skid_in_ready got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_op !== 3'b010 || out_rd_addr !== 5'd4) begin errors++; $display("[TB] FAIL skid_hold got v%b op%b rd%0d want v1 op010 rd4", out_valid, out_op, out_rd_addr); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_op !== 3'b100 || out_rd_addr !== 5'd5) begin errors++; $display("[TB] FAIL skid_second got v%b op%b rd%0d want v1 op100 rd5", out_valid, out_op, out_rd_addr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL skid_ready_back got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL skid_drain got %b want 0", out_valid); end
  endtask

  task automatic test_forward_snoop();
    out_ready = 1'b0;
    set_req(3'b000, 5'd5, 5'd10, 5'd12, 32'h12345678, 32'h3F800000);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hC0A00000;
    tick();
    in_valid = 1'b0; wb_en = 1'b0;
    checks++; if (out_read_data1 !== 32'hC0A00000 || out_nan !== 1'b0) begin errors++; $display("[TB] FAIL forward_data got %h nan%b want c0a00000 nan0", out_read_data1, out_nan); end
    tick();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h7FA00000;
    tick();
    wb_en = 1'b0;
    checks++; if (out_read_data1 !== 32'h7FA00000) begin errors++; $display("[TB] FAIL snoop_data got %h want 7fa00000", out_read_data1); end
    checks++; if (out_nan !== 1'b1 || out_snan !== 1'b1) begin errors++; $display("[TB] FAIL snoop_flags got nan%b snan%b want 11", out_nan, out_snan); end
    checks++; if (out_op !== 3'b001 || out_rd_addr !== 5'd12) begin errors++; $display("[TB] FAIL snoop_stable got %b/%0d want 001/12", out_op, out_rd_addr); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || out_nan !== 1'b0) begin errors++; $display("[TB] FAIL snoop_drain got v%b nan%b want 00", out_valid, out_nan); end
  endtask

  task automatic test_illegal();
    set_req(3'b011, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL illegal_handshake got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (illegal_op !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL illegal_pulse got ill%b v%b want ill1 v0", illegal_op, out_valid); end
    tick();
    checks++; if (illegal_op !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL illegal_end got ill%b v%b want ill0 v0", illegal_op, out_valid); end
  endtask

  task automatic fill_both();
    out_ready = 1'b0;
    set_req(3'b000, 5'd1, 5'd2, 5'd20, 32'h7FC00000, 32'h0);
    tick();
    set_req(3'b010, 5'd3, 5'd4, 5'd21, 32'h1, 32'h2);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    fill_both();
    set_req(3'b001, 5'd5, 5'd6, 5'd22, 32'h5, 32'h6);
    flush = 1'b1; out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_clear got v%b rdy%b want v0 rdy1", out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_noaccept got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    fill_both();
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_read_data1 !== 32'd0 || out_op !== 3'b000 || out_rd_addr !== 5'd0) begin errors++; $display("[TB] FAIL rstmid_out got v%b d%h op%b rd%0d want zeros", out_valid, out_read_data1, out_op, out_rd_addr); end
    checks++; if (out_nan !== 1'b0 || out_snan !== 1'b0 || illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_flags got %b%b%b want 000", out_nan, out_snan, illegal_op); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stale got %b want 0", out_valid); end
    end
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1: return {r[31], 8'hFF, 1'b1, r[21:0]};
      2: return {r[31], 8'hFF, 1'b0, r[21:0]};
      default: return 32'h3F800000;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0] f3;
    for (int c = 0; c < 600; c++) begin
      f3        = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      set_req(f3, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom), rand_data(), rand_data());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_addr   = 5'($urandom_range(0, 3));
      wb_data   = rand_data();
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 79) == 0);
      tick();
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("[TB] FAIL rand_valid cycle %0d got %b want %b", c, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (out_read_data1 !== q[0].d1 || out_read_data2 !== q[0].d2) begin errors++; $display("[TB] FAIL rand_data cycle %0d got %h/%h want %h/%h", c, out_read_data1, out_read_data2, q[0].d1, q[0].d2); end
        checks++; if (out_op !== ref_op(q[0].f3) || out_rd_addr !== q[0].rd) begin errors++; $display("[TB] FAIL rand_op cycle %0d got %b/%0d want %b/%0d", c, out_op, out_rd_addr, ref_op(q[0].f3), q[0].rd); end
      end
      checks++; if (out_nan !== (q.size() != 0 && (ref_nan(q[0].d1) || ref_nan(q[0].d2)))) begin errors++; $display("[TB] FAIL rand_nan cycle %0d got %b", c, out_nan); end
      checks++; if (out_snan !== (q.size() != 0 && (ref_snan(q[0].d1) || ref_snan(q[0].d2)))) begin errors++; $display("[TB] FAIL rand_snan cycle %0d got %b", c, out_snan); end
      checks++; if (illegal_op !== m_illegal) begin errors++; $display("[TB] FAIL rand_illegal cycle %0d got %b want %b", c, illegal_op, m_illegal); end
      checks++; if (in_ready !== (q.size() < 2 && !flush && !rst)) begin errors++; $display("[TB] FAIL rand_in_ready cycle %0d got %b want %b", c, in_ready, q.size() < 2 && !flush && !rst); end
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_funct3 = 3'b000;
    in_rs1_addr = 5'd0; in_rs2_addr = 5'd0; in_rd_addr = 5'd0;
    in_read_data1 = 32'd0; in_read_data2 = 32'd0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; out_ready = 1'b0;
    test_reset();
    test_single_op();
    test_stall_skid();
    test_forward_snoop();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_cmp_issue.md
# fp_cmp_issue

Operand issue stage that sits directly upstream of the single-precision compare unit (the FLE/FLT/FEQ comparator). It accepts decoded FP compare instructions with register-file read data and applies writeback forwarding. It decodes funct3 into a one-hot compare select and classifies NaN operands. Results are presented through a valid/ready output register backed by a one-entry skid buffer, so the comparator and its consumer can stall without dropping operations.

## Interface
- NAN_EXP, 8'hFF, exponent pattern that marks Inf/NaN
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered operations this cycle
- in_valid  in  1  request valid
- in_ready  out  1  stage can accept a request
- in_funct3  in  3  000=FLE, 001=FLT, 010=FEQ, others illegal
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  5 each  FP source / integer dest register indices
- in_read_data1, in_read_data2  in  32 each  FP register-file read data
- wb_en  in  1  FP writeback strobe
- wb_addr  in  5  FP writeback index
- wb_data  in  32  FP writeback value
- out_valid  out  1  issued operation valid
- out_ready  in  1  comparator/consumer accepts
- out_read_data1, out_read_data2  out  32 each  forwarded operands
- out_op  out  3  one-hot {feq, flt, fle}
- out_rd_addr  out  5  destination index
- out_nan  out  1  either operand is NaN (quiet or signalling)
- out_snan  out  1  either operand is a signalling NaN
- illegal_op  out  1  one-cycle pulse: an illegal funct3 was accepted and dropped

## Operation
- Storage: output register (OR) plus one skid entry (SK). Each holds: data1, data2, rs1_addr, rs2_addr, op, rd_addr, and a valid bit.
- The stage accepts a request when in_valid && in_ready.
- in_ready = !SK.valid && !flush && !rst.
- Forwarding at acceptance: if wb_en && wb_addr==in_rs1_addr, capture wb_data instead of in_read_data1. The same rule applies to rs2. f0 is an ordinary register and has no special case.
- Snooping: every cycle, for each valid OR/SK entry, if wb_en && wb_addr equals the stored rs1 (or rs2) address, overwrite the stored data1 (or data2) with wb_data.
- Decode: 000 gives op=001, 001 gives op=010, 010 gives op=100. Any other funct3 is accepted (handshake completes) but not stored, and illegal_op pulses high in the next cycle.
- Routing of a legal accepted request:
  - If OR is empty, or OR is consumed this cycle and SK is empty, the request loads OR.
  - Otherwise it loads SK (OR full and stalled).
- Consumption: when out_valid && out_ready, OR is released. If SK is valid, SK moves to OR in that same edge and SK empties. Otherwise OR takes the new legal request if one is accepted, else OR empties.
- Ordering is strictly FIFO. OR always holds the older operation.
- Classification is combinational from OR contents, so it reflects snooped data:
  - NaN = exp==NAN_EXP && mant!=0.
  - sNaN = NaN && mant[22]==0.
  - out_nan and out_snan are each the OR of both operands' flags, gated by OR.valid.
- flush clears OR.valid and SK.valid on the next edge. A request presented in a flush cycle is not accepted. flush overrides a simultaneous out_ready consumption, which is treated as a don't-care.

## Timing
- Reset values: out_valid=0, out_read_data1/2=0, out_op=000, out_rd_addr=0, out_nan=0, out_snan=0, illegal_op=0. in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Latency: one cycle from acceptance to out_valid when OR is free.
- Throughput: one op per cycle while out_ready stays high.
- While out_valid && !out_ready, all out_* fields stay stable. The one exception is operand data updated by a snoop; out_op and out_rd_addr never change.
- in_ready drops in the cycle after SK fills, and rises in the cycle after SK drains. Because SK absorbs the in-flight request, no request is lost.
- A writeback coinciding with acceptance is forwarded in that same cycle. A writeback one or more cycles later is applied by snooping.
- An illegal funct3 never raises out_valid. illegal_op lasts exactly one cycle per illegal acceptance.
- Reset asserted mid-operation clears both entries at the next edge, and no partial op is issued.

## Test plan
- **Single op:** after reset, FLE with data1=3F800000, data2=40000000, out_ready=1. Expect out_valid one cycle later, op=001, operands unchanged, out_nan=0.
- **Stall and skid:** out_ready=0, issue FLT then FEQ back-to-back. Expect in_ready=0 after the second acceptance and OR holding FLT. Then raise out_ready: FLT issues, then FEQ the next cycle, and in_ready=1.
- **Forwarding and snoop:** issue FLE with rs1=5 while wb_en=1, wb_addr=5, wb_data=C0A00000. Expect out_read_data1=C0A00000. With out_ready=0, a later write of wb_addr=5, wb_data=7FA00000 must update out_read_data1, setting out_nan=1 and out_snan=1.
- **Illegal funct3:** issue funct3=011. Expect the handshake to complete, illegal_op high for one cycle, and out_valid to stay 0.
- **Flush:** fill OR and SK, then assert flush together with in_valid=1. Expect out_valid=0 next cycle, nothing accepted, and in_ready=1.
- **Reset mid-stall:** with OR and SK full, assert rst. Expect all outputs at reset values next cycle and no stale issue afterward.
